operand_fetch: RTL and testbench

Operand-fetch stage of the 16-bit CPU: the initiator that drives the 4×16-bit register file's read and write ports. Accepts decoded instructions over a valid/ready handshake, stalls on register hazards using a per-register busy scoreboard, issues the register-file read, and presents both operands to execute with forwarding from writeback. Also routes writeback results into the register file's write port.

---
 rtl/operand_fetch_pkg.sv | 22 ++
 rtl/operand_fetch_if.sv | 62 ++++++
 rtl/operand_fetch_reg_scoreboard.sv | 38 +++
 rtl/operand_fetch.sv | 116 +++++++++++
 tb/tb_operand_fetch.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// ============================================================================
// cpu_pkg : widths and operand-fetch FSM state type shared by the CPU slice
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int ADR_W    = 2;
  localparam int NUM_REGS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    READ  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/operand_fetch_if.sv
// ============================================================================
// operand_fetch_if : decode, execute, writeback and register-file signals
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface operand_fetch_if;
  import cpu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ADR_W-1:0]  in_rs1;
  logic [ADR_W-1:0]  in_rs2;
  logic [ADR_W-1:0]  in_rd;
  logic              in_wen;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_op1;
  logic [DATA_W-1:0] out_op2;
  logic [ADR_W-1:0]  out_rd;
  logic              out_wen;

  logic              wb_valid;
  logic [ADR_W-1:0]  wb_adr;
  logic [DATA_W-1:0] wb_data;

  logic              rf_read_en;
  logic [ADR_W-1:0]  rf_read_adr1;
  logic [ADR_W-1:0]  rf_read_adr2;
  logic [DATA_W-1:0] rf_read_data1;
  logic [DATA_W-1:0] rf_read_data2;
  logic              rf_write_en;
  logic [ADR_W-1:0]  rf_write_adr;
  logic [DATA_W-1:0] rf_write_data;

  // master is the operand-fetch stage itself
  modport master (
    input  in_valid, in_rs1, in_rs2, in_rd, in_wen,
    input  out_ready,
    input  wb_valid, wb_adr, wb_data,
    input  rf_read_data1, rf_read_data2,
    output in_ready,
    output out_valid, out_op1, out_op2, out_rd, out_wen,
    output rf_read_en, rf_read_adr1, rf_read_adr2,
    output rf_write_en, rf_write_adr, rf_write_data
  );

  modport slave (
    output in_valid, in_rs1, in_rs2, in_rd, in_wen,
    output out_ready,
    output wb_valid, wb_adr, wb_data,
    output rf_read_data1, rf_read_data2,
    input  in_ready,
    input  out_valid, out_op1, out_op2, out_rd, out_wen,
    input  rf_read_en, rf_read_adr1, rf_read_adr2,
    input  rf_write_en, rf_write_adr, rf_write_data
  );

endinterface

`default_nettype wire

// File: rtl/operand_fetch_reg_scoreboard.sv
// ============================================================================
// reg_scoreboard : per-register busy bits, set on issue, cleared on writeback
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_set,
  input  logic [ADR_W-1:0]    i_set_adr,
  input  logic                i_clr,
  input  logic [ADR_W-1:0]    i_clr_adr,
  output logic [NUM_REGS-1:0] o_busy
);

  logic [NUM_REGS-1:0] r_busy;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_busy
    // a new producer outranks a retiring one on the same register
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_busy[i] <= 1'b0;
      end else if (i_set && (i_set_adr == ADR_W'(i))) begin
        r_busy[i] <= 1'b1;
      end else if (i_clr && (i_clr_adr == ADR_W'(i))) begin
        r_busy[i] <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// operand_fetch : hazard-checked register read with writeback forwarding
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module operand_fetch
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  operand_fetch_if.master bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADR_W-1:0]    r_rs1;
  logic [ADR_W-1:0]    r_rs2;
  logic [ADR_W-1:0]    r_rd;
  logic                r_wen;
  logic [DATA_W-1:0]   r_op1;
  logic [DATA_W-1:0]   r_op2;
  logic [ADR_W-1:0]    r_out_rd;
  logic                r_out_wen;
  logic [NUM_REGS-1:0] w_busy;
  logic                w_stall;
  logic                w_read_en;
  logic                w_set;
  logic [DATA_W-1:0]   w_op1;
  logic [DATA_W-1:0]   w_op2;

  reg_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .i_set     (w_set),
    .i_set_adr (r_rd),
    .i_clr     (bus.wb_valid),
    .i_clr_adr (bus.wb_adr),
    .o_busy    (w_busy)
  );

  assign w_stall = w_busy[r_rs1] | w_busy[r_rs2] | (r_wen & w_busy[r_rd]);

  // the register file is written on the capture edge, so its read data is stale
  assign w_op1 = (bus.wb_valid && (bus.wb_adr == r_rs1)) ? bus.wb_data : bus.rf_read_data1;
  assign w_op2 = (bus.wb_valid && (bus.wb_adr == r_rs2)) ? bus.wb_data : bus.rf_read_data2;

  always_comb begin
    w_state_nxt = r_state;
    w_read_en   = 1'b0;
    w_set       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) w_state_nxt = CHECK;
      end
      CHECK: begin
        if (!w_stall) begin
          w_read_en   = 1'b1;
          w_state_nxt = READ;
        end
      end
      READ: begin
        w_set       = r_wen;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_wen     <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_out_rd  <= '0;
      r_out_wen <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && bus.in_valid) begin
        r_rs1 <= bus.in_rs1;
        r_rs2 <= bus.in_rs2;
        r_rd  <= bus.in_rd;
        r_wen <= bus.in_wen;
      end
      if (r_state == READ) begin
        r_op1     <= w_op1;
        r_op2     <= w_op2;
        r_out_rd  <= r_rd;
        r_out_wen <= r_wen;
      end
    end
  end

  assign bus.in_ready      = (r_state == IDLE);
  assign bus.out_valid     = (r_state == HOLD);
  assign bus.out_op1       = r_op1;
  assign bus.out_op2       = r_op2;
  assign bus.out_rd        = r_out_rd;
  assign bus.out_wen       = r_out_wen;
  assign bus.rf_read_en    = w_read_en;
  assign bus.rf_read_adr1  = r_rs1;
  assign bus.rf_read_adr2  = r_rs2;
  assign bus.rf_write_en   = bus.wb_valid & reset;
  assign bus.rf_write_adr  = bus.wb_adr;
  assign bus.rf_write_data = bus.wb_data;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// tb_operand_fetch : directed bench with a latest-value register model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // register file stub: synchronous read returns the pre-edge contents
  logic [DATA_W-1:0] rf_mem [NUM_REGS] = '{16'hCCCC, 16'hAAAA, 16'h0000, 16'h5555};
  always @(posedge clk) begin
    if (bus.rf_write_en) rf_mem[bus.rf_write_adr] <= bus.rf_write_data;
    if (bus.rf_read_en) begin
      bus.rf_read_data1 <= rf_mem[bus.rf_read_adr1];
      bus.rf_read_data2 <= rf_mem[bus.rf_read_adr2];
    end
  end

  // model: an operand is the latest value written to its register, and a
  // register with an outstanding producer blocks the read
  logic [DATA_W-1:0]   m_arch [NUM_REGS] = '{16'hCCCC, 16'hAAAA, 16'h0000, 16'h5555};
  logic [NUM_REGS-1:0] m_busy     = '0;
  logic                m_inflight = 1'b0;
  logic                m_issued   = 1'b0;
  logic                m_valid    = 1'b0;
  logic [ADR_W-1:0]    m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic                m_wen = 1'b0;
  logic [DATA_W-1:0]   m_op1 = '0, m_op2 = '0;

  function automatic logic blocked(input logic [NUM_REGS-1:0] b, input logic [ADR_W-1:0] s1,
                                   input logic [ADR_W-1:0] s2, input logic [ADR_W-1:0] d,
                                   input logic w);
    return b[s1] | b[s2] | (w & b[d]);
  endfunction

  always @(posedge clk) begin : model
    logic [DATA_W-1:0]   arch_n [NUM_REGS];
    logic [NUM_REGS-1:0] busy_n;
    arch_n = m_arch;
    busy_n = m_busy;
    if (!reset) begin
      busy_n     = '0;
      m_inflight <= 1'b0;
      m_issued   <= 1'b0;
      m_valid    <= 1'b0;
    end else begin
      if (bus.wb_valid) begin
        arch_n[bus.wb_adr] = bus.wb_data;
        busy_n[bus.wb_adr] = 1'b0;
      end
      if (m_valid) begin
        if (bus.out_ready) begin
          m_valid    <= 1'b0;
          m_inflight <= 1'b0;
        end
      end else if (m_inflight && m_issued) begin
        m_op1 <= arch_n[m_rs1];
        m_op2 <= arch_n[m_rs2];
        if (m_wen) busy_n[m_rd] = 1'b1;
        m_valid <= 1'b1;
      end else if (m_inflight) begin
        if (!blocked(m_busy, m_rs1, m_rs2, m_rd, m_wen)) m_issued <= 1'b1;
      end else if (bus.in_valid) begin
        m_rs1      <= bus.in_rs1;
        m_rs2      <= bus.in_rs2;
        m_rd       <= bus.in_rd;
        m_wen      <= bus.in_wen;
        m_inflight <= 1'b1;
        m_issued   <= 1'b0;
      end
    end
    m_arch <= arch_n;
    m_busy <= busy_n;
  end

  always @(negedge clk) begin : compare
    logic exp_rd;
    if (chk_on) begin
      exp_rd = m_inflight && !m_issued && !m_valid &&
               !blocked(m_busy, m_rs1, m_rs2, m_rd, m_wen);
      chk("in_ready", bus.in_ready, !m_inflight);
      chk("out_valid", bus.out_valid, m_valid);
      chk("rf_read_en", bus.rf_read_en, exp_rd);
      if (exp_rd) begin
        chk("rf_read_adr1", bus.rf_read_adr1, m_rs1);
        chk("rf_read_adr2", bus.rf_read_adr2, m_rs2);
      end
      chk("rf_write_en", bus.rf_write_en, bus.wb_valid & reset);
      if (bus.wb_valid && reset) begin
        chk("rf_write_adr", bus.rf_write_adr, bus.wb_adr);
        chk("rf_write_data", bus.rf_write_data, bus.wb_data);
      end
      chk("busy", dut.u_sb.o_busy, m_busy);
      if (m_valid) begin
        chk("out_op1", bus.out_op1, m_op1);
        chk("out_op2", bus.out_op2, m_op2);
        chk("out_rd", bus.out_rd, m_rd);
        chk("out_wen", bus.out_wen, m_wen);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [ADR_W-1:0] rs1, input logic [ADR_W-1:0] rs2,
                       input logic [ADR_W-1:0] rd, input logic wen);
    bus.in_valid = 1'b1;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
    bus.in_wen   = wen;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wb(input logic v, input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wb_valid = v;
    bus.wb_adr   = a;
    bus.wb_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_rd     = '0;
    bus.in_wen    = 1'b0;
    bus.out_ready = 1'b1;
    wb(1'b1, 2'd2, 16'hDEAD);
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;

    // reset values, writeback suppressed while in reset
    @(negedge clk);
    chk("rst_rf_write_en", bus.rf_write_en, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_op1", bus.out_op1, 16'h0000);
    chk("rst_op2", bus.out_op2, 16'h0000);
    chk("rst_rd_wen", {bus.out_rd, bus.out_wen}, 3'b000);
    chk("rst_rf_read_en", bus.rf_read_en, 1'b0);
    chk("rst_busy", dut.u_sb.o_busy, 4'b0000);
    tick();
    reset = 1'b1;
    wb(1'b0, 2'd0, 16'h0000);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // no hazard
    tick();
    issue(2'd0, 2'd1, 2'd2, 1'b1);
    @(negedge clk);
    chk("nh_read_en", bus.rf_read_en, 1'b1);
    chk("nh_adr", {bus.rf_read_adr1, bus.rf_read_adr2}, 4'b0001);
    tick();
    @(negedge clk);
    chk("nh_read_pulse", bus.rf_read_en, 1'b0);
    chk("nh_not_valid_yet", bus.out_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("nh_valid", bus.out_valid, 1'b1);
    chk("nh_op1", bus.out_op1, 16'hCCCC);
    chk("nh_op2", bus.out_op2, 16'hAAAA);
    chk("nh_busy", dut.u_sb.o_busy, 4'b0100);
    tick();
    @(negedge clk);
    chk("nh_back_idle", bus.in_ready, 1'b1);

    // RAW stall on R2, released by writeback
    tick();
    issue(2'd2, 2'd0, 2'd3, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("raw_stall", bus.rf_read_en, 1'b0);
      tick();
    end
    wb(1'b1, 2'd2, 16'hFFFF);
    @(negedge clk);
    chk("raw_stall_wb_cycle", bus.rf_read_en, 1'b0);
    tick();
    wb(1'b0, 2'd0, 16'h0000);
    @(negedge clk);
    chk("raw_read_issued", bus.rf_read_en, 1'b1);
    chk("raw_busy_cleared", dut.u_sb.o_busy, 4'b0000);
    tick();
    tick();
    @(negedge clk);
    chk("raw_op1", bus.out_op1, 16'hFFFF);
    chk("raw_op2", bus.out_op2, 16'hCCCC);
    tick();

    // bypass of a writeback landing during READ
    tick();
    issue(2'd0, 2'd3, 2'd0, 1'b0);
    tick();
    wb(1'b1, 2'd3, 16'h1234);
    tick();
    wb(1'b0, 2'd0, 16'h0000);
    @(negedge clk);
    chk("byp_op1", bus.out_op1, 16'hCCCC);
    chk("byp_op2", bus.out_op2, 16'h1234);
    tick();

    // backpressure, rs1 == rs2
    tick();
    bus.out_ready = 1'b0;
    issue(2'd1, 2'd1, 2'd3, 1'b1);
    tick();
    tick();
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_ops", {bus.out_op1, bus.out_op2}, 32'hAAAA_AAAA);
      chk("bp_rd", bus.out_rd, 2'd3);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_last_valid", bus.out_valid, 1'b1);
    tick();
    @(negedge clk);
    chk("bp_released", {bus.in_ready, bus.out_valid}, 2'b10);
    chk("bp_busy", dut.u_sb.o_busy, 4'b1000);

    // set and clear of busy[1] on the same edge
    tick();
    issue(2'd0, 2'd0, 2'd1, 1'b1);
    tick();
    wb(1'b1, 2'd1, 16'h7777);
    tick();
    wb(1'b0, 2'd0, 16'h0000);
    @(negedge clk);
    chk("col_busy", dut.u_sb.o_busy, 4'b1010);
    chk("col_ops", {bus.out_op1, bus.out_op2}, 32'hCCCC_CCCC);
    tick();

    // reset while stalled in CHECK
    tick();
    issue(2'd3, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    chk("mr_stalled", bus.rf_read_en, 1'b0);
    tick();
    reset = 1'b0;
    wb(1'b1, 2'd3, 16'h9999);
    @(negedge clk);
    chk("mr_no_write", bus.rf_write_en, 1'b0);
    tick();
    reset = 1'b1;
    wb(1'b0, 2'd0, 16'h0000);
    @(negedge clk);
    chk("mr_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    chk("mr_busy", dut.u_sb.o_busy, 4'b0000);
    chk("mr_op1", bus.out_op1, 16'h0000);

    // register contents after the dropped writeback
    tick();
    issue(2'd3, 2'd1, 2'd2, 1'b0);
    tick();
    tick();
    @(negedge clk);
    chk("post_op1", bus.out_op1, 16'h1234);
    chk("post_op2", bus.out_op2, 16'h7777);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
